muldiv_seq: RTL and testbench

//  Sequencer for RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).

---
 rtl/muldiv_seq_pkg.sv | 32 +++
 rtl/muldiv_seq_div_step.sv | 25 ++
 rtl/muldiv_seq.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// rtl/muldiv_seq_pkg.sv - shared widths, funct3 codes and FSM state constants for muldiv_seq.
package muldiv_seq_pkg;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int CNT_W = $clog2(XLEN);

  typedef logic [XLEN-1:0]  data_t;
  typedef logic [TAG_W-1:0] r_t;
  typedef logic [2:0]       funct3_t;
  typedef logic [2:0]       muldiv_state_t;

  localparam funct3_t F3_MUL    = 3'b000;
  localparam funct3_t F3_MULH   = 3'b001;
  localparam funct3_t F3_MULHSU = 3'b010;
  localparam funct3_t F3_MULHU  = 3'b011;
  localparam funct3_t F3_DIV    = 3'b100;
  localparam funct3_t F3_DIVU   = 3'b101;
  localparam funct3_t F3_REM    = 3'b110;
  localparam funct3_t F3_REMU   = 3'b111;

  localparam muldiv_state_t S_IDLE = 3'd0;
  localparam muldiv_state_t S_MUL  = 3'd1;
  localparam muldiv_state_t S_DIV  = 3'd2;
  localparam muldiv_state_t S_FIX  = 3'd3;
  localparam muldiv_state_t S_DONE = 3'd4;

  function automatic data_t abs_val(input data_t v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? data_t'(-v) : v;
  endfunction

endpackage

// File: rtl/muldiv_seq_div_step.sv
// rtl/muldiv_seq_div_step.sv - one combinational restoring-division step (one quotient bit).
module muldiv_seq_div_step
  import muldiv_seq_pkg::*;
(
  input  data_t rem_i,
  input  data_t quot_i,
  input  data_t divisor_i,
  output data_t rem_o,
  output data_t quot_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          fits;

  // The quotient register doubles as the dividend shifter: its MSB feeds the remainder.
  always_comb begin
    shifted = {rem_i, quot_i[XLEN-1]};
    diff    = shifted - {1'b0, divisor_i};
    fits    = ~diff[XLEN];
    rem_o   = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quot_o  = {quot_i[XLEN-2:0], fits};
  end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - RV32M multiply/divide sequencer for the EX stage.
// Define MULDIV_EARLY_OUT_EN to shortcut trivial divides (x/0, overflow, |A|<|B|) to 2 cycles.
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    start,
  input  logic    flush,
  input  funct3_t funct3,
  input  data_t   rs1,
  input  data_t   rs2,
  input  r_t      rd_in,
  output logic    busy,
  output logic    done,
  output data_t   result,
  output r_t      rd_out
);

  muldiv_state_t    state_q, state_d;
  funct3_t          f3_q, f3_d;
  data_t            a_q, a_d, b_q, b_d;
  data_t            rem_q, rem_d, quot_q, quot_d;
  data_t            result_q, result_d;
  r_t               tag_q, tag_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             negq_q, negq_d, negr_q, negr_d;

  logic                     signed_div, sa, sb;
  data_t                    abs_a, abs_b;
  logic                     a_sgn, b_sgn;
  logic signed [2*XLEN-1:0] a_ext, b_ext, prod;
  data_t                    mul_res, div_res, step_rem, step_quot;

  muldiv_seq_div_step u_step (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (b_q),
    .rem_o     (step_rem),
    .quot_o    (step_quot)
  );

  always_comb begin
    signed_div = ~funct3[0];
    sa         = signed_div & rs1[XLEN-1];
    sb         = signed_div & rs2[XLEN-1];
    abs_a      = abs_val(rs1, signed_div);
    abs_b      = abs_val(rs2, signed_div);

    a_sgn   = (f3_q != F3_MULHU);
    b_sgn   = (f3_q == F3_MULH) || (f3_q == F3_MUL);
    a_ext   = {{XLEN{a_sgn & a_q[XLEN-1]}}, a_q};
    b_ext   = {{XLEN{b_sgn & b_q[XLEN-1]}}, b_q};
    prod    = a_ext * b_ext;
    mul_res = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    div_res = f3_q[1] ? (negr_q ? data_t'(-rem_q) : rem_q)
                      : (negq_q ? data_t'(-quot_q) : quot_q);
  end

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    result_d = result_q;
    tag_d    = tag_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d  = funct3;
          tag_d = rd_in;
          if (!funct3[2]) begin
            a_d     = rs1;
            b_d     = rs2;
            state_d = S_MUL;
          end else begin
            // A zero divisor keeps the all-ones quotient positive regardless of sign(A).
            b_d     = abs_b;
            quot_d  = abs_a;
            rem_d   = '0;
            negq_d  = (sa ^ sb) && (rs2 != '0);
            negr_d  = sa;
            cnt_d   = CNT_W'(XLEN-1);
            state_d = S_DIV;
`ifdef MULDIV_EARLY_OUT_EN
            if (rs2 == '0) begin
              quot_d  = '1;
              rem_d   = rs1;
              negq_d  = 1'b0;
              negr_d  = 1'b0;
              state_d = S_FIX;
            end else if (signed_div && rs1 == {1'b1, {(XLEN-1){1'b0}}} && rs2 == '1) begin
              quot_d  = rs1;
              rem_d   = '0;
              negq_d  = 1'b0;
              negr_d  = 1'b0;
              state_d = S_FIX;
            end else if (abs_a < abs_b) begin
              quot_d  = '0;
              rem_d   = rs1;
              negq_d  = 1'b0;
              negr_d  = 1'b0;
              state_d = S_FIX;
            end
`endif
          end
        end
      end
      S_MUL: begin
        result_d = mul_res;
        rd_d     = tag_q;
        state_d  = S_DONE;
      end
      S_DIV: begin
        rem_d  = step_rem;
        quot_d = step_quot;
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        result_d = div_res;
        rd_d     = tag_q;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort discards the op entirely, including any result about to be written.
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
      rd_d     = rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      result_q <= '0;
      tag_q    <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      result_q <= result_d;
      tag_q    <= tag_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - randomized self-checking bench for muldiv_seq against an arithmetic model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 2;
`else
  localparam int SPECIAL_LAT = 34;
`endif

  muldiv_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = 64'(ua / ub); return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = 64'(ua % ub); return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    logic   sgn;
    if (!f3[2]) return 2;
    sgn = !f3[0];
    ma  = (sgn && a[31]) ? -longint'($signed(a)) : longint'({32'b0, a});
    mb  = (sgn && b[31]) ? -longint'($signed(b)) : longint'({32'b0, b});
    if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || ma < mb)
      return SPECIAL_LAT;
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // poke > 0 re-pulses start with different operands in that cycle of the op.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int poke,
                        output int lat, output logic [31:0] res, output logic [4:0] rd);
    int   cyc;
    logic seen;
    @(negedge clk);
    funct3 = f3; rs1 = a; rs2 = b; rd_in = tag; start = 1'b1;
    @(posedge clk);
    cyc = 1; seen = 1'b0; lat = -1; res = 'x; rd = 'x;
    while (cyc <= 100 && !seen) begin
      @(negedge clk);
      start = (poke > 0 && cyc == poke);
      if (start) begin
        rs1 = ~a; rs2 = a ^ b ^ 32'h5A5A_0001; rd_in = ~tag;
      end
      if (done) begin
        seen = 1'b1; lat = cyc; res = result; rd = rd_out;
      end else begin
        @(posedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  initial begin
    vec_t        dir[9];
    int          lat, pulses;
    logic [31:0] res, prev;
    logic [4:0]  rd, tag;
    logic [2:0]  f3;
    logic [31:0] a, b;

    dir[0] = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 2};
    dir[1] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
    dir[2] = '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 2};
    dir[3] = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34};
    dir[4] = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34};
    dir[5] = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, SPECIAL_LAT};
    dir[6] = '{3'd7, 32'd5,         32'd0,         32'd5,         SPECIAL_LAT};
    dir[7] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT};
    dir[8] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         SPECIAL_LAT};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_rd_out", 32'(rd_out), 32'd0);

    foreach (dir[i]) begin
      tag = 5'(i + 1);
      run_op(dir[i].f3, dir[i].a, dir[i].b, tag, 0, lat, res, rd);
      check($sformatf("dir%0d_result", i), res, dir[i].exp);
      check($sformatf("dir%0d_latency", i), 32'(lat), 32'(dir[i].lat));
      check($sformatf("dir%0d_rd", i), 32'(rd), 32'(tag));
    end

    for (int i = 0; i < 40; i++) begin
      f3  = 3'($urandom_range(0, 7));
      a   = pick_operand();
      b   = pick_operand();
      tag = 5'($urandom);
      run_op(f3, a, b, tag, 0, lat, res, rd);
      check($sformatf("rnd%0d_f%0d_result", i, f3), res, ref_result(f3, a, b));
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(ref_latency(f3, a, b)));
      check($sformatf("rnd%0d_rd", i), 32'(rd), 32'(tag));
    end

    // Start re-pulsed mid-divide must not disturb the op in flight.
    run_op(3'd4, 32'd1000, 32'd7, 5'd9, 3, lat, res, rd);
    check("busy_start_result", res, 32'd142);
    check("busy_start_latency", 32'(lat), 32'd34);
    check("busy_start_rd", 32'(rd), 32'd9);
    prev = res;

    // Flush in cycle 10 of a divide.
    @(negedge clk);
    funct3 = 3'd5; rs1 = 32'd12345; rs2 = 32'd11; rd_in = 5'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("flush_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_after", 32'(busy), 32'd0);
    check("flush_no_done", 32'(done), 32'd0);
    check("flush_result_kept", result, prev);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("flush_no_late_done", 32'(pulses), 32'd0);
    run_op(3'd7, 32'd12345, 32'd11, 5'd17, 0, lat, res, rd);
    check("post_flush_result", res, 32'd3);
    check("post_flush_rd", 32'(rd), 32'd17);

    // Flush beats start in the same cycle.
    @(negedge clk);
    funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd4; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_beats_start", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
